// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register owner and multiply sequencer (optional timeout: HILO_TIMEOUT_EN)
module hilo_unit #(
  parameter int TIMEOUT = 48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        op_ready,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        mult_end,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        mult_err
);

  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_MFHI = 3'b010;
  localparam logic [2:0] OP_MFLO = 3'b011;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;
  logic   accept;
  logic   capture;
  logic   timeout_hit;
  logic   wait_first;

`ifdef HILO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT[0];
`endif

  assign accept = op_valid && op_ready;

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and handshake outputs; the first WAIT cycle ignores a stale done level
  always_comb begin
    state_nx    = state;
    op_ready    = 1'b0;
    mult_start  = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid && op == OP_MULT) state_nx = START;
      end
      START: begin
        mult_start = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: begin
        if (!wait_first && mult_end) begin
          capture  = 1'b1;
          state_nx = IDLE;
        end
`ifdef HILO_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nx    = IDLE;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // WAIT bookkeeping: first-cycle flag (and cycle counter when the timeout is built in)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_first <= 1'b0;
`ifdef HILO_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else if (state == START) begin
      wait_first <= 1'b1;
`ifdef HILO_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else if (state == WAIT) begin
      wait_first <= 1'b0;
`ifdef HILO_TIMEOUT_EN
      wait_cnt   <= wait_cnt + 1'b1;
`endif
    end
  end

  // operand latches, HI/LO registers and read port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mult_a   <= '0;
      mult_b   <= '0;
      hi       <= '0;
      lo       <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) begin
        case (op)
          OP_MULT: begin
            mult_a <= rs_data;
            mult_b <= rt_data;
          end
          OP_MFHI: begin
            rd_data  <= hi;
            rd_valid <= 1'b1;
          end
          OP_MFLO: begin
            rd_data  <= lo;
            rd_valid <= 1'b1;
          end
          OP_MTHI: hi <= rs_data;
          OP_MTLO: lo <= rs_data;
          default: ;
        endcase
      end
      if (capture) begin
        hi <= mult_hi;
        lo <= mult_lo;
      end
    end
  end

`ifdef HILO_TIMEOUT_EN
  // sticky timeout flag, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           mult_err <= 1'b0;
    else if (timeout_hit) mult_err <= 1'b1;
  end
`else
  assign mult_err = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - self-checking bench for hilo_unit with a behavioural multiplier
module tb_hilo_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        op_ready, mult_start;
  logic [31:0] mult_a, mult_b;
  logic [31:0] mult_hi, mult_lo;
  logic        mult_end;
  logic [31:0] hi, lo, rd_data;
  logic        rd_valid, mult_err;

  int n_vec = 0;
  int n_err = 0;
  int n_starts = 0;
  logic [31:0] rd_q[$];

  hilo_unit #(.TIMEOUT(48)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .op_ready(op_ready),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .mult_end(mult_end),
    .hi(hi), .lo(lo), .rd_data(rd_data), .rd_valid(rd_valid), .mult_err(mult_err)
  );

  always #5 clock = ~clock;

  // behavioural multiplier: done level rises 31 edges after start is sampled,
  // and the previous done level lingers for one edge after the new start
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_prod;
  logic        stuck_low = 1'b0;
  initial begin
    mult_end = 1'b0;
    mult_hi  = '0;
    mult_lo  = '0;
  end
  always @(posedge clock) begin
    if (mult_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 1;
      m_prod <= $signed({{32{mult_a[31]}}, mult_a}) * $signed({{32{mult_b[31]}}, mult_b});
    end else if (m_busy) begin
      if (m_cnt == 1) mult_end <= 1'b0;
      if (m_cnt == 31) begin
        mult_end <= !stuck_low;
        if (!stuck_low) {mult_hi, mult_lo} <= m_prod;
        m_busy <= 1'b0;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // start counter and read-result scoreboard
  always @(negedge clock) begin
    if (mult_start) n_starts++;
    if (rd_valid) begin
      if (rd_q.size() == 0) chk("rd_valid_unexpected", 32'd1, 32'd0);
      else chk("rd_data", rd_data, rd_q.pop_front());
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    @(negedge clock);
    op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
    while (!op_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!op_ready) chk("issue_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1 op_valid = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    @(negedge clock);
    while (!op_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt, exp_rd, exp_hi, exp_lo;
    int          exp_busy;
  } vec_t;

  vec_t vecs[12];
  int   busy, s0, guard;

  initial begin
    vecs[0]  = '{3'b001, 32'd7,          32'hFFFFFFFD, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'b100, 32'hDEADBEEF,   32'h0,        32'h0,        32'hDEADBEEF, 32'hFFFFFFEB, 0};
    vecs[2]  = '{3'b101, 32'h12345678,   32'h0,        32'h0,        32'hDEADBEEF, 32'h12345678, 0};
    vecs[3]  = '{3'b010, 32'h0,          32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678, 0};
    vecs[4]  = '{3'b011, 32'h0,          32'h0,        32'h12345678, 32'hDEADBEEF, 32'h12345678, 0};
    vecs[5]  = '{3'b001, 32'd5,          32'd6,        32'h0,        32'h0,        32'd30,       33};
    vecs[6]  = '{3'b001, 32'd2,          32'd3,        32'h0,        32'h0,        32'd6,        33};
    vecs[7]  = '{3'b111, 32'h55555555,   32'h1,        32'h0,        32'h0,        32'd6,        0};
    vecs[8]  = '{3'b000, 32'hAAAAAAAA,   32'h1,        32'h0,        32'h0,        32'd6,        0};
    vecs[9]  = '{3'b001, 32'h80000000,   32'd2,        32'h0,        32'hFFFFFFFF, 32'h0,        33};
    vecs[10] = '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h0,        32'h0,        32'd1,        33};
    vecs[11] = '{3'b010, 32'h0,          32'h0,        32'h0,        32'h0,        32'd1,        0};

    reset = 1'b0; op_valid = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    repeat (3) @(negedge clock);
    chk("reset_op_ready", {31'd0, op_ready}, 32'd1);
    chk("reset_mult_start", {31'd0, mult_start}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_mult_a", mult_a, 32'd0);
    chk("reset_rd", {rd_data[31:1], rd_valid}, 32'd0);
    chk("reset_mult_err", {31'd0, mult_err}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      s0 = n_starts;
      if (vecs[i].op == 3'b010 || vecs[i].op == 3'b011) rd_q.push_back(vecs[i].exp_rd);
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      busy_len(busy);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_starts", i), n_starts - s0, (vecs[i].op == 3'b001) ? 1 : 0);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // MTHI then MFHI, MFLO on consecutive edges
    @(negedge clock);
    op_valid = 1'b1; op = 3'b100; rs_data = 32'hCAFEF00D;
    @(posedge clock); #1 op = 3'b010; rd_q.push_back(32'hCAFEF00D);
    @(posedge clock); #1 op = 3'b011; rd_q.push_back(32'd1);
    @(posedge clock); #1 op_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("b2b_hi", hi, 32'hCAFEF00D);

    // MFLO held during a multiply is taken only when ready returns
    @(negedge clock);
    op_valid = 1'b1; op = 3'b001; rs_data = 32'd9; rt_data = 32'd10;
    @(posedge clock); #1 op = 3'b011; rd_q.push_back(32'd90);
    guard = 0;
    @(negedge clock);
    while (!op_ready && guard < 200) begin
      guard++;
      @(negedge clock);
    end
    chk("held_wait", guard, 33);
    @(posedge clock); #1 op_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("held_lo", lo, 32'd90);

    // reset in the middle of WAIT
    issue(3'b001, 32'd4, 32'd4);
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_op_ready", {31'd0, op_ready}, 32'd1);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_mult_b", mult_b, 32'd0);
    chk("midrst_start", {31'd0, mult_start}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("postrst_end_seen", {31'd0, mult_end}, 32'd1);
    chk("postrst_hi", hi, 32'd0);
    chk("postrst_lo", lo, 32'd0);
    chk("postrst_ready", {31'd0, op_ready}, 32'd1);

`ifdef HILO_TIMEOUT_EN
    issue(3'b100, 32'h0000A5A5, 32'h0);
    stuck_low = 1'b1;
    issue(3'b001, 32'd3, 32'd3);
    busy_len(busy);
    chk("timeout_busy", busy, 49);
    chk("timeout_err", {31'd0, mult_err}, 32'd1);
    chk("timeout_hi", hi, 32'h0000A5A5);
    chk("timeout_lo", lo, 32'd0);
    stuck_low = 1'b0;
`else
    chk("mult_err_tied", {31'd0, mult_err}, 32'd0);
`endif

    repeat (3) @(negedge clock);
    chk("rd_queue_drained", rd_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
